// File: rtl/ddr_bank_sequencer.sv
// ddr_bank_sequencer
//   Multi-bank DDR command sequencer. Tracks the open row of every bank and
//   converts each accepted read/write request into the minimal
//   PRCH/ACTV/READ/WRTE sequence, honouring tRP/tRCD spacing, and inserts a
//   periodic auto-refresh (PRCH-all when needed, then AREF and tRFC wait).
//
// Ports
//   CLK           clock
//   RST           asynchronous active-low reset
//   REQ_VALID     request present
//   REQ_WE        1 = write, 0 = read
//   REQ_BANK      target bank
//   REQ_ROW       target row
//   REQ_READY     request accepted when REQ_VALID & REQ_READY
//   COMMAND       command bus: 0 NOP, 1 PRCH, 2 ACTV, 3 READ, 4 WRTE, 5 AREF
//   CMD_BANK      bank for COMMAND
//   CMD_ROW       row for ACTV
//   CMD_ALL       with PRCH: precharge all banks (A10)
//   DO_WRITE      high in the cycle WRTE is on COMMAND
//   REFRESH_BUSY  refresh pending or refresh sequence in progress
//
// All outputs are registered; the state register always names the state whose
// command is currently on COMMAND.

module ddr_bank_sequencer #(
   parameter int ROW_W  = 12,
   parameter int BANK_W = 2,
   parameter int T_RP   = 3,
   parameter int T_RCD  = 2,
   parameter int T_RFC  = 10,
   parameter int T_REFI = 1560
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              REQ_VALID,
   input  logic              REQ_WE,
   input  logic [BANK_W-1:0] REQ_BANK,
   input  logic [ROW_W-1:0]  REQ_ROW,
   output logic              REQ_READY,
   output logic [2:0]        COMMAND,
   output logic [BANK_W-1:0] CMD_BANK,
   output logic [ROW_W-1:0]  CMD_ROW,
   output logic              CMD_ALL,
   output logic              DO_WRITE,
   output logic              REFRESH_BUSY
);

   localparam int BANKS    = 2 ** BANK_W;
   localparam int WAIT_MAX = (T_RP > T_RCD) ? ((T_RP > T_RFC) ? T_RP : T_RFC)
                                            : ((T_RCD > T_RFC) ? T_RCD : T_RFC);
   localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
   localparam int REF_W    = $clog2(T_REFI + 1);

   // Wait loads count the NOP cycles left after the first one.
   localparam logic [WAIT_W-1:0] RP_LOAD   = WAIT_W'((T_RP  > 1) ? T_RP  - 2 : 0);
   localparam logic [WAIT_W-1:0] RCD_LOAD  = WAIT_W'((T_RCD > 1) ? T_RCD - 2 : 0);
   localparam logic [WAIT_W-1:0] RFC_LOAD  = WAIT_W'((T_RFC > 1) ? T_RFC - 2 : 0);
   localparam logic [REF_W-1:0]  REFI_LOAD = REF_W'(T_REFI);

   typedef enum logic [2:0] {
      CMD_NOP  = 3'd0,
      CMD_PRCH = 3'd1,
      CMD_ACTV = 3'd2,
      CMD_READ = 3'd3,
      CMD_WRTE = 3'd4,
      CMD_AREF = 3'd5
   } cmd_e;

   typedef enum logic [3:0] {
      IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, RW,
      REF_PRE, REF_WAIT_RP, REF, REF_WAIT_RFC
   } state_e;

   state_e              state;
   logic [BANKS-1:0]    bank_open;
   logic [ROW_W-1:0]    bank_row [BANKS];
   logic                lat_we;
   logic [BANK_W-1:0]   lat_bank;
   logic [ROW_W-1:0]    lat_row;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [REF_W-1:0]    ref_cnt;
   logic                refresh_pending;
   logic                ref_expire;
   logic                req_hit;

   always_comb begin
      req_hit    = 1'b0;
      ref_expire = (ref_cnt == '0);
      if (bank_open[REQ_BANK] && (bank_row[REQ_BANK] == REQ_ROW))
         req_hit = 1'b1;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state           <= IDLE;
         COMMAND         <= CMD_NOP;
         CMD_BANK        <= '0;
         CMD_ROW         <= '0;
         CMD_ALL         <= 1'b0;
         DO_WRITE        <= 1'b0;
         REQ_READY       <= 1'b0;
         REFRESH_BUSY    <= 1'b0;
         bank_open       <= '0;
         for (int unsigned i = 0; i < BANKS; i++)
            bank_row[i] <= '0;
         lat_we          <= 1'b0;
         lat_bank        <= '0;
         lat_row         <= '0;
         wait_cnt        <= '0;
         ref_cnt         <= REFI_LOAD;
         refresh_pending <= 1'b0;
      end else begin
         COMMAND      <= CMD_NOP;
         CMD_ALL      <= 1'b0;
         DO_WRITE     <= 1'b0;
         REQ_READY    <= 1'b0;
         // Busy follows the next value of refresh_pending unless a REF_*
         // state is entered below.
         REFRESH_BUSY <= refresh_pending | ref_expire;

         case (state)
            IDLE: begin
               if (refresh_pending) begin
                  REFRESH_BUSY <= 1'b1;
                  CMD_BANK     <= '0;
                  if (|bank_open) begin
                     state     <= REF_PRE;
                     COMMAND   <= CMD_PRCH;
                     CMD_ALL   <= 1'b1;
                     bank_open <= '0;
                  end else begin
                     state           <= REF;
                     COMMAND         <= CMD_AREF;
                     refresh_pending <= 1'b0;
                  end
               end else if (REQ_VALID && REQ_READY) begin
                  lat_we   <= REQ_WE;
                  lat_bank <= REQ_BANK;
                  lat_row  <= REQ_ROW;
                  CMD_BANK <= REQ_BANK;
                  if (req_hit) begin
                     state    <= RW;
                     COMMAND  <= REQ_WE ? CMD_WRTE : CMD_READ;
                     DO_WRITE <= REQ_WE;
                  end else if (bank_open[REQ_BANK]) begin
                     state               <= PRE;
                     COMMAND             <= CMD_PRCH;
                     bank_open[REQ_BANK] <= 1'b0;
                  end else begin
                     state               <= ACT;
                     COMMAND             <= CMD_ACTV;
                     CMD_ROW             <= REQ_ROW;
                     bank_open[REQ_BANK] <= 1'b1;
                     bank_row[REQ_BANK]  <= REQ_ROW;
                  end
               end else begin
                  REQ_READY <= !ref_expire;
               end
            end

            PRE, WAIT_RP: begin
               if ((state == PRE) ? (T_RP == 1) : (wait_cnt == '0)) begin
                  state               <= ACT;
                  COMMAND             <= CMD_ACTV;
                  CMD_BANK            <= lat_bank;
                  CMD_ROW             <= lat_row;
                  bank_open[lat_bank] <= 1'b1;
                  bank_row[lat_bank]  <= lat_row;
               end else begin
                  state    <= WAIT_RP;
                  wait_cnt <= (state == PRE) ? RP_LOAD : wait_cnt - 1'b1;
               end
            end

            ACT, WAIT_RCD: begin
               if ((state == ACT) ? (T_RCD == 1) : (wait_cnt == '0)) begin
                  state    <= RW;
                  COMMAND  <= lat_we ? CMD_WRTE : CMD_READ;
                  CMD_BANK <= lat_bank;
                  DO_WRITE <= lat_we;
               end else begin
                  state    <= WAIT_RCD;
                  wait_cnt <= (state == ACT) ? RCD_LOAD : wait_cnt - 1'b1;
               end
            end

            RW: begin
               state     <= IDLE;
               REQ_READY <= !(refresh_pending | ref_expire);
            end

            REF_PRE, REF_WAIT_RP: begin
               REFRESH_BUSY <= 1'b1;
               if ((state == REF_PRE) ? (T_RP == 1) : (wait_cnt == '0)) begin
                  state           <= REF;
                  COMMAND         <= CMD_AREF;
                  CMD_BANK        <= '0;
                  refresh_pending <= 1'b0;
               end else begin
                  state    <= REF_WAIT_RP;
                  wait_cnt <= (state == REF_PRE) ? RP_LOAD : wait_cnt - 1'b1;
               end
            end

            REF, REF_WAIT_RFC: begin
               if ((state == REF) ? (T_RFC == 1) : (wait_cnt == '0)) begin
                  state     <= IDLE;
                  REQ_READY <= !(refresh_pending | ref_expire);
               end else begin
                  REFRESH_BUSY <= 1'b1;
                  state        <= REF_WAIT_RFC;
                  wait_cnt     <= (state == REF) ? RFC_LOAD : wait_cnt - 1'b1;
               end
            end

            default: state <= IDLE;
         endcase

         // Placed after the FSM so an expiry coinciding with AREF stays pending.
         if (ref_expire) begin
            ref_cnt         <= REFI_LOAD;
            refresh_pending <= 1'b1;
         end else begin
            ref_cnt <= ref_cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ddr_bank_sequencer.sv
module tb_ddr_bank_sequencer;

   localparam int ROW_W  = 12;
   localparam int BANK_W = 2;
   localparam int T_RP   = 3;
   localparam int T_RCD  = 2;
   localparam int T_RFC  = 10;
   localparam int T_REFI = 1560;

   localparam logic [2:0] C_NOP  = 3'd0;
   localparam logic [2:0] C_PRCH = 3'd1;
   localparam logic [2:0] C_ACTV = 3'd2;
   localparam logic [2:0] C_READ = 3'd3;
   localparam logic [2:0] C_WRTE = 3'd4;
   localparam logic [2:0] C_AREF = 3'd5;

   logic              CLK = 1'b0;
   logic              RST = 1'b0;
   logic              REQ_VALID = 1'b0;
   logic              REQ_WE = 1'b0;
   logic [BANK_W-1:0] REQ_BANK = '0;
   logic [ROW_W-1:0]  REQ_ROW = '0;
   logic              REQ_READY;
   logic [2:0]        COMMAND;
   logic [BANK_W-1:0] CMD_BANK;
   logic [ROW_W-1:0]  CMD_ROW;
   logic              CMD_ALL;
   logic              DO_WRITE;
   logic              REFRESH_BUSY;

   int errors = 0;
   int checks = 0;
   int ncyc   = 0;
   int arefs  = 0;

   ddr_bank_sequencer #(
      .ROW_W (ROW_W),
      .BANK_W(BANK_W),
      .T_RP  (T_RP),
      .T_RCD (T_RCD),
      .T_RFC (T_RFC),
      .T_REFI(T_REFI)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .REQ_VALID   (REQ_VALID),
      .REQ_WE      (REQ_WE),
      .REQ_BANK    (REQ_BANK),
      .REQ_ROW     (REQ_ROW),
      .REQ_READY   (REQ_READY),
      .COMMAND     (COMMAND),
      .CMD_BANK    (CMD_BANK),
      .CMD_ROW     (CMD_ROW),
      .CMD_ALL     (CMD_ALL),
      .DO_WRITE    (DO_WRITE),
      .REFRESH_BUSY(REFRESH_BUSY)
   );

   always #5 CLK = ~CLK;

   // Clock edges since reset release.
   always @(posedge CLK or negedge RST) begin
      if (!RST) ncyc <= 0;
      else      ncyc <= ncyc + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      chk(tag, 32'(obs), 32'(exp));
   endtask

   // Command check; bank is checked for bank-directed commands, CMD_ALL for
   // PRCH, DO_WRITE in every cycle.
   task automatic chk_cmd(input string tag, input logic [2:0] c,
                          input logic [BANK_W-1:0] b, input logic all);
      chk({tag, ".cmd"}, 32'(COMMAND), 32'(c));
      chk_bit({tag, ".do_write"}, DO_WRITE, (c == C_WRTE));
      if (c == C_PRCH)
         chk_bit({tag, ".all"}, CMD_ALL, all);
      if ((c == C_ACTV) || (c == C_READ) || (c == C_WRTE) || ((c == C_PRCH) && !all))
         chk({tag, ".bank"}, 32'(CMD_BANK), 32'(b));
   endtask

   task automatic chk_row(input string tag, input logic [ROW_W-1:0] r);
      chk(tag, 32'(CMD_ROW), 32'(r));
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_req(input logic we, input logic [BANK_W-1:0] b, input logic [ROW_W-1:0] r);
      REQ_VALID = 1'b1;
      REQ_WE    = we;
      REQ_BANK  = b;
      REQ_ROW   = r;
      step();
      REQ_VALID = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      int guard = 0;
      while ((ncyc < n) && (guard < 5000)) begin
         step();
         guard++;
      end
      chk("wait_cyc", 32'(ncyc), 32'(n));
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge CLK);
      #1;
      chk_cmd("rst", C_NOP, '0, 1'b0);
      chk_bit("rst.ready", REQ_READY, 1'b0);
      chk_bit("rst.busy", REFRESH_BUSY, 1'b0);
      chk_bit("rst.all", CMD_ALL, 1'b0);
      chk("rst.bank", 32'(CMD_BANK), 32'd0);
      chk_row("rst.row", '0);
      RST = 1'b1;
      step();
      chk_bit("rel.ready", REQ_READY, 1'b1);
      chk_cmd("rel", C_NOP, '0, 1'b0);

      // Closed bank: ACTV, tRCD, READ, ready again
      do_req(1'b0, 2'd1, 12'h00A);
      chk_cmd("t1.actv", C_ACTV, 2'd1, 1'b0);
      chk_row("t1.row", 12'h00A);
      chk_bit("t1.ready_lo", REQ_READY, 1'b0);
      step(); chk_cmd("t1.rcd", C_NOP, '0, 1'b0);
      step(); chk_cmd("t1.read", C_READ, 2'd1, 1'b0);
      step(); chk_cmd("t1.idle", C_NOP, '0, 1'b0);
      chk_bit("t1.ready", REQ_READY, 1'b1);

      // Hits: read then write
      do_req(1'b0, 2'd1, 12'h00A);
      chk_cmd("t2.read", C_READ, 2'd1, 1'b0);
      step(); chk_cmd("t2.idle", C_NOP, '0, 1'b0);
      chk_bit("t2.ready", REQ_READY, 1'b1);
      do_req(1'b1, 2'd1, 12'h00A);
      chk_cmd("t2.wrte", C_WRTE, 2'd1, 1'b0);
      step(); chk_cmd("t2.idle2", C_NOP, '0, 1'b0);
      chk_bit("t2.ready2", REQ_READY, 1'b1);

      // Miss: PRCH, tRP, ACTV, tRCD, READ
      do_req(1'b0, 2'd1, 12'h0FF);
      chk_cmd("t3.prch", C_PRCH, 2'd1, 1'b0);
      step(); chk_cmd("t3.rp1", C_NOP, '0, 1'b0);
      step(); chk_cmd("t3.rp2", C_NOP, '0, 1'b0);
      step(); chk_cmd("t3.actv", C_ACTV, 2'd1, 1'b0);
      chk_row("t3.row", 12'h0FF);
      step(); chk_cmd("t3.rcd", C_NOP, '0, 1'b0);
      step(); chk_cmd("t3.read", C_READ, 2'd1, 1'b0);
      step(); chk_bit("t3.ready", REQ_READY, 1'b1);
      do_req(1'b0, 2'd1, 12'h0FF);
      chk_cmd("t3.hit", C_READ, 2'd1, 1'b0);
      step();

      // Open bank 0 and bank 2
      do_req(1'b0, 2'd0, 12'h011);
      chk_cmd("t4.open0", C_ACTV, 2'd0, 1'b0);
      step(); step(); chk_cmd("t4.read0", C_READ, 2'd0, 1'b0);
      step();
      do_req(1'b1, 2'd2, 12'h022);
      chk_cmd("t4.open2", C_ACTV, 2'd2, 1'b0);
      step(); step(); chk_cmd("t4.wrte2", C_WRTE, 2'd2, 1'b0);
      step();

      // Refresh with banks open and a request held
      wait_cyc(T_REFI);
      chk_bit("t4.pre_ready", REQ_READY, 1'b1);
      chk_bit("t4.pre_busy", REFRESH_BUSY, 1'b0);
      step();
      chk_bit("t4.busy", REFRESH_BUSY, 1'b1);
      chk_bit("t4.ready_lo", REQ_READY, 1'b0);
      REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_BANK = 2'd0; REQ_ROW = 12'h011;
      step(); chk_cmd("t4.prch_all", C_PRCH, '0, 1'b1);
      chk_bit("t4.ready_lo2", REQ_READY, 1'b0);
      step(); chk_cmd("t4.rp1", C_NOP, '0, 1'b0);
      step(); chk_cmd("t4.rp2", C_NOP, '0, 1'b0);
      step(); chk_cmd("t4.aref", C_AREF, '0, 1'b0);
      chk_bit("t4.busy_aref", REFRESH_BUSY, 1'b1);
      for (int i = 0; i < T_RFC - 1; i++) begin
         step();
         chk_cmd("t4.rfc", C_NOP, '0, 1'b0);
         chk_bit("t4.rfc_ready", REQ_READY, 1'b0);
      end
      step();
      chk_bit("t4.ready_back", REQ_READY, 1'b1);
      chk_bit("t4.busy_done", REFRESH_BUSY, 1'b0);
      step();
      chk_cmd("t4.actv_closed", C_ACTV, 2'd0, 1'b0);
      chk_row("t4.row", 12'h011);
      REQ_VALID = 1'b0;
      step(); step(); chk_cmd("t4.read", C_READ, 2'd0, 1'b0);
      step();
      do_req(1'b1, 2'd2, 12'h022);
      chk_cmd("t4.actv2_closed", C_ACTV, 2'd2, 1'b0);
      step(); step(); step();

      // Refresh expiry in the middle of a miss sequence
      wait_cyc(2 * (T_REFI + 1) - 3);
      chk_bit("t5.ready", REQ_READY, 1'b1);
      do_req(1'b0, 2'd0, 12'h033);
      chk_cmd("t5.prch", C_PRCH, 2'd0, 1'b0);
      step(); chk_cmd("t5.rp1", C_NOP, '0, 1'b0);
      step(); chk_bit("t5.busy", REFRESH_BUSY, 1'b1);
      step(); chk_cmd("t5.actv", C_ACTV, 2'd0, 1'b0);
      chk_row("t5.row", 12'h033);
      step(); chk_cmd("t5.rcd", C_NOP, '0, 1'b0);
      step(); chk_cmd("t5.read", C_READ, 2'd0, 1'b0);
      step(); chk_bit("t5.ready_lo", REQ_READY, 1'b0);
      step(); chk_cmd("t5.prch_all", C_PRCH, '0, 1'b1);
      step(); step();
      step(); chk_cmd("t5.aref", C_AREF, '0, 1'b0);
      arefs = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (COMMAND == C_AREF) arefs++;
         if (i == T_RFC - 1) chk_bit("t5.ready_back", REQ_READY, 1'b1);
      end
      chk("t5.extra_aref", 32'(arefs), 32'd0);

      // Asynchronous reset during WAIT_RCD
      do_req(1'b1, 2'd3, 12'h044);
      chk_cmd("t6.actv", C_ACTV, 2'd3, 1'b0);
      step(); chk_cmd("t6.rcd", C_NOP, '0, 1'b0);
      RST = 1'b0;
      #2;
      chk("t6.async_bank", 32'(CMD_BANK), 32'd0);
      chk_row("t6.async_row", '0);
      chk_cmd("t6.async_cmd", C_NOP, '0, 1'b0);
      chk_bit("t6.async_ready", REQ_READY, 1'b0);
      chk_bit("t6.async_busy", REFRESH_BUSY, 1'b0);
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b1;
      step();
      chk_bit("t6.ready", REQ_READY, 1'b1);
      do_req(1'b1, 2'd3, 12'h044);
      chk_cmd("t6.reactv", C_ACTV, 2'd3, 1'b0);
      chk_row("t6.row", 12'h044);
      step(); step(); chk_cmd("t6.wrte", C_WRTE, 2'd3, 1'b0);
      step();
      do_req(1'b0, 2'd0, 12'h033);
      chk_cmd("t6.bank0_closed", C_ACTV, 2'd0, 1'b0);
      step(); step(); step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
